// File: rtl/sort_engine_merge_stage_nway.sv
// -----------------------------------------------------------------------------
// sort_engine_merge_stage_nway
//
// Run-aware N-way merge stage for the sort engine merge tree. Each output group
// takes one sorted run from each of its RADIX input streams and emits a single
// merged sorted run whose final element carries `last`. Merged elements are
// buffered in a 2-entry FIFO per group, so input ready never depends on output
// ready, and a group sustains one element per clock.
//
// Optional feature macro: SORT_ENGINE_MERGE_STATS_EN
//   defined     -> adds run_cnt_o, a 16-bit wrapping count of merged runs
//                  popped from each group.
//   not defined -> run_cnt_o and its counters are absent.
//
// Parameters
//   DWIDTH        element width in bits
//   IN_DATA_CNT   number of input streams (a power of RADIX)
//   RADIX         merge fan-in per group (2 or 4)
//   DESCEND       0 = ascending, 1 = descending
//   OUT_DATA_CNT  derived, IN_DATA_CNT/RADIX (leave at its default)
//
// Ports
//   clk_i             clock
//   rst_n_i           asynchronous reset, active-low
//   data_in_i         input elements, group g owns streams g*RADIX .. g*RADIX+RADIX-1
//   data_in_val_i     per-stream input valid
//   data_in_last_i    per-stream final element of the current run
//   data_in_ready_o   per-stream input ready
//   data_out_o        merged elements, one per group
//   data_out_val_o    per-group output valid
//   data_out_last_o   per-group final element of the merged run
//   data_out_ready_i  per-group output ready
//   run_cnt_o         per-group merged-run counter (stats build only)
// -----------------------------------------------------------------------------
module sort_engine_merge_stage_nway #(
  parameter int DWIDTH       = 8,
  parameter int IN_DATA_CNT  = 16,
  parameter int RADIX        = 2,
  parameter bit DESCEND      = 1'b0,
  parameter int OUT_DATA_CNT = IN_DATA_CNT / RADIX
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [IN_DATA_CNT*DWIDTH-1:0]  data_in_i,
  input  logic [IN_DATA_CNT-1:0]         data_in_val_i,
  input  logic [IN_DATA_CNT-1:0]         data_in_last_i,
  output logic [IN_DATA_CNT-1:0]         data_in_ready_o,
  output logic [OUT_DATA_CNT*DWIDTH-1:0] data_out_o,
  output logic [OUT_DATA_CNT-1:0]        data_out_val_o,
  output logic [OUT_DATA_CNT-1:0]        data_out_last_o,
  input  logic [OUT_DATA_CNT-1:0]        data_out_ready_i
`ifdef SORT_ENGINE_MERGE_STATS_EN
  ,
  output logic [OUT_DATA_CNT*16-1:0]     run_cnt_o
`endif
);

  localparam int SEL_W = $clog2(RADIX);

  // True when element a must leave before element b in the configured order.
  // Strict compare, so equal heads keep the lower stream index (stable merge).
  function automatic logic goes_first(input logic [DWIDTH-1:0] a,
                                      input logic [DWIDTH-1:0] b);
    logic res;
    if (DESCEND) begin
      res = (a > b);
    end else begin
      res = (a < b);
    end
    return res;
  endfunction

  genvar g;
  generate
    for (g = 0; g < OUT_DATA_CNT; g++) begin : g_grp
      logic [DWIDTH-1:0] head_s [RADIX];
      logic [RADIX-1:0]  val_s;
      logic [RADIX-1:0]  last_s;
      logic [RADIX-1:0]  ready_s;
      logic [RADIX-1:0]  sel_oh_s;
      logic [RADIX-1:0]  done_r;
      logic [SEL_W-1:0]  sel_s;
      logic [DWIDTH-1:0] best_s;
      logic              stall_s;
      logic              found_s;
      logic              push_s;
      logic              push_last_s;
      logic              pop_s;
      logic [1:0]        cnt_r;
      logic              val_r;
      logic              accept_en_r;
      logic [DWIDTH-1:0] e0_data_r;
      logic [DWIDTH-1:0] e1_data_r;
      logic              e0_last_r;
      logic              e1_last_r;

      // Slice this group's streams out of the flat input buses.
      always_comb begin
        for (int i = 0; i < RADIX; i++) begin
          head_s[i] = data_in_i[(g*RADIX+i)*DWIDTH +: DWIDTH];
          val_s[i]  = data_in_val_i[g*RADIX+i];
          last_s[i] = data_in_last_i[g*RADIX+i];
        end
      end

      // Pick the winning head among streams still inside the current run; a
      // missing head on any such stream makes the order unknown, so stall.
      always_comb begin
        stall_s = 1'b0;
        found_s = 1'b0;
        sel_s   = '0;
        best_s  = '0;
        for (int i = 0; i < RADIX; i++) begin
          if (!done_r[i]) begin
            if (!val_s[i]) begin
              stall_s = 1'b1;
            end else begin
              stall_s = stall_s;
            end
            if (!found_s || goes_first(head_s[i], best_s)) begin
              found_s = 1'b1;
              sel_s   = SEL_W'(i);
              best_s  = head_s[i];
            end else begin
              found_s = found_s;
            end
          end else begin
            found_s = found_s;
          end
        end
      end

      // Ready goes only to the winner, and only while the FIFO has room by its
      // registered count; the output ready never reaches this path.
      always_comb begin
        sel_oh_s        = '0;
        sel_oh_s[sel_s] = 1'b1;
        if (accept_en_r && found_s && !stall_s && (cnt_r != 2'd2)) begin
          ready_s = sel_oh_s;
        end else begin
          ready_s = '0;
        end
      end

      // A push closes the merged run when the winner ends its run and every
      // other stream of the group has already ended its run.
      always_comb begin
        push_s      = |(ready_s & val_s);
        push_last_s = last_s[sel_s] && ((done_r | sel_oh_s) == {RADIX{1'b1}});
        pop_s       = val_r && data_out_ready_i[g];
      end

      // Input ready is held low while in reset and for the first clock after.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          accept_en_r <= 1'b0;
        end else begin
          accept_en_r <= 1'b1;
        end
      end

      // Per-stream run-finished flags; all clear together when the run closes.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          done_r <= '0;
        end else if (push_s) begin
          if (push_last_s) begin
            done_r <= '0;
          end else if (last_s[sel_s]) begin
            done_r <= done_r | sel_oh_s;
          end else begin
            done_r <= done_r;
          end
        end else begin
          done_r <= done_r;
        end
      end

      // Two-entry shift FIFO: entry 0 is always the head and drives the
      // outputs straight from flops. A push never happens while full.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          cnt_r     <= 2'd0;
          val_r     <= 1'b0;
          e0_data_r <= '0;
          e0_last_r <= 1'b0;
          e1_data_r <= '0;
          e1_last_r <= 1'b0;
        end else begin
          case (cnt_r)
            2'd0: begin
              if (push_s) begin
                e0_data_r <= best_s;
                e0_last_r <= push_last_s;
                cnt_r     <= 2'd1;
                val_r     <= 1'b1;
              end else begin
                cnt_r <= 2'd0;
              end
            end
            2'd1: begin
              if (push_s && pop_s) begin
                e0_data_r <= best_s;
                e0_last_r <= push_last_s;
              end else if (push_s) begin
                e1_data_r <= best_s;
                e1_last_r <= push_last_s;
                cnt_r     <= 2'd2;
              end else if (pop_s) begin
                cnt_r <= 2'd0;
                val_r <= 1'b0;
              end else begin
                cnt_r <= 2'd1;
              end
            end
            2'd2: begin
              if (pop_s) begin
                e0_data_r <= e1_data_r;
                e0_last_r <= e1_last_r;
                cnt_r     <= 2'd1;
              end else begin
                cnt_r <= 2'd2;
              end
            end
            default: begin
              cnt_r <= 2'd0;
              val_r <= 1'b0;
            end
          endcase
        end
      end

      assign data_in_ready_o[g*RADIX +: RADIX]  = ready_s;
      assign data_out_o[g*DWIDTH +: DWIDTH]     = e0_data_r;
      assign data_out_last_o[g]                 = e0_last_r;
      assign data_out_val_o[g]                  = val_r;

`ifdef SORT_ENGINE_MERGE_STATS_EN
      logic [15:0] run_cnt_r;

      // Count merged runs leaving the group; wraps naturally at 16 bits.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          run_cnt_r <= 16'd0;
        end else if (pop_s && e0_last_r) begin
          run_cnt_r <= run_cnt_r + 16'd1;
        end else begin
          run_cnt_r <= run_cnt_r;
        end
      end

      assign run_cnt_o[g*16 +: 16] = run_cnt_r;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_sort_engine_merge_stage_nway.sv
// -----------------------------------------------------------------------------
// Bench for sort_engine_merge_stage_nway. Two instances run side by side:
//   u_a : 4 streams, RADIX=2, ascending  (groups 0 and 1)
//   u_b : 4 streams, RADIX=4, descending (group 2 in bench numbering)
// Bench stream index 0..3 feeds u_a, 4..7 feeds u_b. The reference for every
// merged run is simply the sorted concatenation of the runs that feed it.
// -----------------------------------------------------------------------------
module tb_sort_engine_merge_stage_nway;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4*DW-1:0] a_din;
  logic [3:0]      a_val, a_last, a_rdy;
  logic [2*DW-1:0] a_dout;
  logic [1:0]      a_oval, a_olast, a_ordy;
  logic [4*DW-1:0] b_din;
  logic [3:0]      b_val, b_last, b_rdy;
  logic [DW-1:0]   b_dout;
  logic [0:0]      b_oval, b_olast, b_ordy;
`ifdef SORT_ENGINE_MERGE_STATS_EN
  logic [31:0]     a_rc;
  logic [15:0]     b_rc;
`endif

  sort_engine_merge_stage_nway #(.DWIDTH(DW), .IN_DATA_CNT(4), .RADIX(2), .DESCEND(1'b0)) u_a (
    .clk_i(clk), .rst_n_i(rst_n),
    .data_in_i(a_din), .data_in_val_i(a_val), .data_in_last_i(a_last), .data_in_ready_o(a_rdy),
    .data_out_o(a_dout), .data_out_val_o(a_oval), .data_out_last_o(a_olast),
    .data_out_ready_i(a_ordy)
`ifdef SORT_ENGINE_MERGE_STATS_EN
    , .run_cnt_o(a_rc)
`endif
  );

  sort_engine_merge_stage_nway #(.DWIDTH(DW), .IN_DATA_CNT(4), .RADIX(4), .DESCEND(1'b1)) u_b (
    .clk_i(clk), .rst_n_i(rst_n),
    .data_in_i(b_din), .data_in_val_i(b_val), .data_in_last_i(b_last), .data_in_ready_o(b_rdy),
    .data_out_o(b_dout), .data_out_val_o(b_oval), .data_out_last_o(b_olast),
    .data_out_ready_i(b_ordy)
`ifdef SORT_ENGINE_MERGE_STATS_EN
    , .run_cnt_o(b_rc)
`endif
  );

  logic [8:0] sq [8][$];   // pending stream elements {last,data}
  int         mq [3][$];   // values of the run currently being assembled
  logic [8:0] eq [3][$];   // expected merged output {last,data}
  logic [7:0] s_dat [8];
  logic       s_val [8];
  logic       s_last [8];
  logic       o_rdy [3];
  logic       acc [8];
  int checks = 0, failures = 0;
  int ocnt = 0, ofirst = 0, olast = 0, acc_total = 0, cyc = 0;
  int runs_seen [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      a_din[i*DW +: DW] = s_dat[i];
      a_val[i]          = s_val[i];
      a_last[i]         = s_last[i];
      b_din[i*DW +: DW] = s_dat[i+4];
      b_val[i]          = s_val[i+4];
      b_last[i]         = s_last[i+4];
    end
    a_ordy[0] = o_rdy[0];
    a_ordy[1] = o_rdy[1];
    b_ordy[0] = o_rdy[2];
  endtask

  function automatic logic in_rdy(input int i);
    if (i < 4) return a_rdy[i];
    else return b_rdy[i-4];
  endfunction

  function automatic logic out_val(input int o);
    if (o < 2) return a_oval[o];
    else return b_oval[0];
  endfunction

  function automatic logic [8:0] out_word(input int o);
    if (o < 2) return {a_olast[o], a_dout[o*DW +: DW]};
    else return {b_olast[0], b_dout};
  endfunction

  task automatic push_run(input int s, input int o, input int v[$]);
    for (int k = 0; k < v.size(); k++) begin
      sq[s].push_back({(k == v.size()-1) ? 1'b1 : 1'b0, 8'(v[k])});
      mq[o].push_back(v[k]);
    end
  endtask

  // Reference merge: the run pair/quad collapses to one sorted run.
  task automatic close_run(input int o, input bit desc);
    if (desc) mq[o].rsort();
    else mq[o].sort();
    for (int k = 0; k < mq[o].size(); k++)
      eq[o].push_back({(k == mq[o].size()-1) ? 1'b1 : 1'b0, 8'(mq[o][k])});
    mq[o].delete();
  endtask

  task automatic rand_runs(input int nruns);
    int v[$];
    int len;
    for (int r = 0; r < nruns; r++) begin
      for (int s = 0; s < 8; s++) begin
        len = $urandom_range(4, 1);
        v.delete();
        for (int k = 0; k < len; k++) v.push_back(int'($urandom_range(31, 0)));
        if (s < 4) v.sort();
        else v.rsort();
        push_run(s, (s < 2) ? 0 : (s < 4) ? 1 : 2, v);
      end
      close_run(0, 1'b0);
      close_run(1, 1'b0);
      close_run(2, 1'b1);
    end
  endtask

  // mode: 0 output always ready, 1 random, 2 never. gap: percent idle on inputs.
  task automatic run(input int budget, input int mode, input int gap,
                     input int max_outs, input bit must_finish);
    bit         idle;
    logic [8:0] w;
    logic [8:0] exp;
    idle = 1'b0;
    for (int c = 0; c < budget && !idle; c++) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < 8; i++) begin
        if (acc[i]) begin
          void'(sq[i].pop_front());
          acc[i]   = 1'b0;
          s_val[i] = 1'b0;
        end
        if (!s_val[i]) begin
          if (sq[i].size() > 0 && $urandom_range(99, 0) >= gap) begin
            s_val[i] = 1'b1;
            {s_last[i], s_dat[i]} = sq[i][0];
          end else begin
            s_val[i]  = 1'b0;
            s_last[i] = 1'($urandom);
            s_dat[i]  = 8'($urandom);
          end
        end
      end
      for (int o = 0; o < 3; o++)
        o_rdy[o] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      apply();
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (s_val[i] && in_rdy(i)) begin
          acc[i] = 1'b1;
          acc_total++;
        end
      end
      for (int o = 0; o < 3; o++) begin
        if (out_val(o) && o_rdy[o]) begin
          w = out_word(o);
          if (eq[o].size() == 0) begin
            check($sformatf("out%0d_extra", o), eq[o].size(), 1);
          end else begin
            exp = eq[o].pop_front();
            check($sformatf("out%0d_elem", o), w, exp);
          end
          ocnt++;
          if (ocnt == 1) ofirst = cyc;
          olast = cyc;
          if (w[8]) runs_seen[o]++;
        end
      end
      idle = 1'b1;
      for (int i = 0; i < 8; i++) if (sq[i].size() > (acc[i] ? 1 : 0)) idle = 1'b0;
      for (int o = 0; o < 3; o++) if (eq[o].size() != 0) idle = 1'b0;
      if (max_outs > 0 && ocnt >= max_outs) idle = 1'b1;
    end
    if (must_finish) check("run_complete", idle, 1'b1);
  endtask

  task automatic settle();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (acc[i]) void'(sq[i].pop_front());
      acc[i]   = 1'b0;
      s_val[i] = 1'b0;
    end
    apply();
  endtask

  task automatic clear_all();
    for (int i = 0; i < 8; i++) begin
      sq[i].delete();
      acc[i]   = 1'b0;
      s_val[i] = 1'b0;
    end
    for (int o = 0; o < 3; o++) begin
      mq[o].delete();
      eq[o].delete();
      runs_seen[o] = 0;
      o_rdy[o]     = 1'b1;
    end
    apply();
  endtask

  initial begin
    int v[$];
    for (int i = 0; i < 8; i++) begin
      s_dat[i]  = 8'd0;
      s_last[i] = 1'b0;
    end
    clear_all();

    // Reset state, with a valid presented to prove ready stays low.
    s_val[0] = 1'b1;
    s_val[4] = 1'b1;
    apply();
    repeat (3) @(posedge clk);
    #1;
    check("rst_oval_a", a_oval, 2'b00);
    check("rst_olast_a", a_olast, 2'b00);
    check("rst_dout_a", a_dout, 16'h0000);
    check("rst_rdy_a", a_rdy, 4'h0);
    check("rst_oval_b", b_oval, 1'b0);
    check("rst_rdy_b", b_rdy, 4'h0);
`ifdef SORT_ENGINE_MERGE_STATS_EN
    check("rst_runcnt_a", a_rc, 32'd0);
`endif
    clear_all();
    @(negedge clk);
    rst_n = 1'b1;
    settle();

    // RADIX=2 ascending basic merge, back-to-back outputs.
    v = {1, 4, 9};  push_run(0, 0, v);
    v = {2, 3, 10}; push_run(1, 0, v);
    close_run(0, 1'b0);
    ocnt = 0;
    run(40, 0, 0, 0, 1'b1);
    check("t1_count", ocnt, 6);
    check("t1_span", olast - ofirst, 5);

    // RADIX=4 descending with a tie inside one stream.
    v = {9, 5}; push_run(4, 2, v);
    v = {8};    push_run(5, 2, v);
    v = {7, 7}; push_run(6, 2, v);
    v = {6};    push_run(7, 2, v);
    close_run(2, 1'b1);
    ocnt = 0;
    run(40, 0, 0, 0, 1'b1);
    check("t2_count", ocnt, 6);

    // Stall: stream0 holds 5 while stream1 is absent.
    settle();
    sq[0].push_back({1'b1, 8'd5});
    mq[0].push_back(5);
    s_val[0] = 1'b1; s_dat[0] = 8'd5; s_last[0] = 1'b1;
    apply();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_rdy", a_rdy[1:0], 2'b00);
      check("stall_oval", a_oval[0], 1'b0);
      @(posedge clk); #1;
    end
    v = {3}; push_run(1, 0, v);
    close_run(0, 1'b0);
    ocnt = 0;
    run(40, 0, 0, 0, 1'b1);
    check("stall_count", ocnt, 2);

    // Back-pressure: only two elements fit.
    v = {1, 4}; push_run(0, 0, v);
    v = {2, 3}; push_run(1, 0, v);
    close_run(0, 1'b0);
    acc_total = 0;
    ocnt = 0;
    run(6, 2, 0, 0, 1'b0);
    check("bp_accepted", acc_total, 2);
    check("bp_rdy", a_rdy[1:0], 2'b00);
    check("bp_oval", a_oval[0], 1'b1);
    check("bp_head", a_dout[7:0], 8'd1);
    run(40, 0, 0, 0, 1'b1);
    check("bp_count", ocnt, 4);

    // Consecutive runs on the same pair of streams.
    for (int o = 0; o < 3; o++) runs_seen[o] = 0;
    v = {1};    push_run(0, 0, v);
    v = {2, 3}; push_run(1, 0, v);
    close_run(0, 1'b0);
    v = {7};    push_run(0, 0, v);
    v = {4};    push_run(1, 0, v);
    close_run(0, 1'b0);
    ocnt = 0;
    run(40, 0, 0, 0, 1'b1);
    check("cons_count", ocnt, 5);
    check("cons_runs", runs_seen[0], 2);

    // Randomised runs, random gaps and back-pressure, all groups at once.
    rand_runs(30);
    run(6000, 1, 30, 0, 1'b1);
    rand_runs(10);
    run(2000, 0, 0, 0, 1'b1);

    // Reset in the middle of a merge.
    settle();
    v = {1, 4, 9};  push_run(0, 0, v);
    v = {2, 3, 10}; push_run(1, 0, v);
    close_run(0, 1'b0);
    ocnt = 0;
    run(40, 0, 0, 2, 1'b0);
    check("mid_outs", ocnt, 2);
    rst_n = 1'b0;
    #1;
    check("mid_oval", a_oval, 2'b00);
    check("mid_olast", a_olast, 2'b00);
    check("mid_dout", a_dout, 16'h0000);
    check("mid_rdy", a_rdy, 4'h0);
`ifdef SORT_ENGINE_MERGE_STATS_EN
    check("mid_runcnt", a_rc, 32'd0);
`endif
    clear_all();
    #2;
    rst_n = 1'b1;
    settle();
    settle();
    v = {5, 6}; push_run(0, 0, v);
    v = {1, 8}; push_run(1, 0, v);
    close_run(0, 1'b0);
    ocnt = 0;
    run(40, 0, 0, 0, 1'b1);
    check("post_rst_count", ocnt, 4);
`ifdef SORT_ENGINE_MERGE_STATS_EN
    check("post_rst_runcnt", a_rc[15:0], 16'(runs_seen[0]));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
